// File: rtl/crc32_append_stage.sv
// Byte-stream pass-through stage that appends a reflected CRC-32 (IEEE 802.3)
// after the last payload byte of each frame, least significant byte first.
`timescale 1ns/1ps
module crc32_append_stage #(
  parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CRC_W  = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CRC_W-1:0] POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [2:0] {PASS, APP0, APP1, APP2, APP3} state_t;

  state_t             state;
  logic [CRC_W-1:0]   crc;
  logic [CRC_W-1:0]   crc_final;
  logic [CRC_W-1:0]   crc_next;
  logic               run;
  logic               out_free;
  logic               accept;

  // One byte of the LSB-first CRC update, eight shift steps unrolled.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] crc_in,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    c = crc_in ^ {(CRC_W-DATA_W)'(0), d};
    for (int i = 0; i < DATA_W; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  // Output register can take a new byte when empty or when its byte leaves now.
  assign out_free = !out_valid || out_ready;
  // run gates in_ready until the first edge after reset release.
  assign in_ready = run && (state == PASS) && out_free;
  assign accept   = in_valid && in_ready;
  assign crc_next = crc_byte(crc, in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PASS;
      crc         <= CRC_INIT;
      crc_final   <= '0;
      run         <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        PASS: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            crc       <= crc_next;
            busy      <= 1'b1;
            if (in_last) begin
              crc_final <= crc_next ^ CRC_XOROUT;
              state     <= APP0;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        APP0: begin
          if (out_free) begin
            out_data  <= crc_final[7:0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= APP1;
          end
        end
        APP1: begin
          if (out_free) begin
            out_data  <= crc_final[15:8];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= APP2;
          end
        end
        APP2: begin
          if (out_free) begin
            out_data  <= crc_final[23:16];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= APP3;
          end
        end
        APP3: begin
          // First load the top CRC byte, then wait for it to transfer.
          if (out_valid && out_last) begin
            if (out_ready) begin
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              crc         <= CRC_INIT;
              busy        <= 1'b0;
              frame_count <= CNT_W'(frame_count + CNT_W'(1));
              state       <= PASS;
            end
          end else if (out_free) begin
            out_data  <= crc_final[31:24];
            out_valid <= 1'b1;
            out_last  <= 1'b1;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_append_stage.sv
// Scoreboard bench for crc32_append_stage: driver queues expected bytes,
// an independent monitor pops and compares on every output transfer.
`timescale 1ns/1ps
module tb_crc32_append_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        busy;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int run_len = 0;
  bit rand_ready = 1'b0;
  logic [8:0] exp_q[$];
  bit prev_hold = 1'b0;
  bit prev_xfer = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic prev_last = 1'b0;

  localparam logic [31:0] CRC_CHECK = 32'hCBF4_3926;
  localparam logic [31:0] CRC_ZERO  = 32'hD202_EF8D;

  always #5 clk = ~clk;

  crc32_append_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .frame_count(frame_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready: constant 1 or a 50% coin toss each cycle.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compare each transferring byte and check hold under back-pressure.
  always @(negedge clk) begin
    bit xfer;
    logic [8:0] e;
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
      prev_xfer = 1'b0;
      run_len = 0;
    end else begin
      if (prev_hold)
        check("hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, prev_last, prev_data});
      xfer = out_valid && out_ready;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {23'd0, out_last, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", {23'd0, out_last, out_data}, {23'd0, e});
        end
        run_len = prev_xfer ? run_len + 1 : 1;
      end
      prev_xfer = xfer;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit hs;
    int n;
    in_data = d; in_last = l; in_valid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 500) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input logic [31:0] crc);
    foreach (pl[i]) exp_q.push_back({1'b0, pl[i]});
    exp_q.push_back({1'b0, crc[7:0]});
    exp_q.push_back({1'b0, crc[15:8]});
    exp_q.push_back({1'b0, crc[23:16]});
    exp_q.push_back({1'b1, crc[31:24]});
    @(posedge clk);
    #1;
    foreach (pl[i]) send_byte(pl[i], (i == pl.size() - 1) ? 1'b1 : 1'b0);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ascii[$];
    logic [7:0] zero[$];
    bit found;
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    zero  = '{8'h00};

    // Reset values while rst_n is low.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_edge", 32'(in_ready), 32'd1);

    // Check string, full throughput.
    send_frame(ascii, CRC_CHECK);
    wait_drain();
    check("consecutive_run", 32'(run_len), 32'd13);
    check("fc_after_check", 32'(frame_count), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);

    // Single zero byte frame.
    send_frame(zero, CRC_ZERO);
    wait_drain();
    check("fc_after_zero", 32'(frame_count), 32'd2);

    // Random back-pressure.
    rand_ready = 1'b1;
    send_frame(ascii, CRC_CHECK);
    wait_drain();
    rand_ready = 1'b0;
    check("fc_after_bp", 32'(frame_count), 32'd3);

    // Back-to-back frames.
    send_frame(ascii, CRC_CHECK);
    send_frame(ascii, CRC_CHECK);
    wait_drain();
    check("fc_after_b2b", 32'(frame_count), 32'd5);

    // Reset while the second CRC byte is being prepared.
    send_frame(ascii, CRC_CHECK);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (out_valid && !out_last && out_data == 8'h26) found = 1'b1;
    end
    check("app1_reached", 32'(found), 32'd1);
    check("app_in_ready", 32'(in_ready), 32'd0);
    check("app_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frame_count", 32'(frame_count), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_stale_bytes", 32'(out_valid), 32'd0);
    send_frame(ascii, CRC_CHECK);
    wait_drain();
    check("fc_after_reset", 32'(frame_count), 32'd1);

    // Counter wrap from 16'hFFFF.
    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    send_frame(zero, CRC_ZERO);
    wait_drain();
    check("fc_wrap", 32'(frame_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
